// File: rtl/alu_pkg.sv
// Shared ALU definitions: operand width, opcode encodings and the flag bundle.
package alu_pkg;

  localparam int ALU_WIDTH = 32;
  localparam int ALU_OPW   = 7;

  typedef logic [ALU_OPW-1:0] opcode_t;

  localparam opcode_t ALU_ADD   = 7'h00;
  localparam opcode_t ALU_SUB   = 7'h01;
  localparam opcode_t ALU_AND   = 7'h02;
  localparam opcode_t ALU_OR    = 7'h03;
  localparam opcode_t ALU_XOR   = 7'h04;
  localparam opcode_t ALU_SLL   = 7'h05;
  localparam opcode_t ALU_SRL   = 7'h06;
  localparam opcode_t ALU_SRA   = 7'h07;
  localparam opcode_t ALU_SLT   = 7'h08;
  localparam opcode_t ALU_SLTU  = 7'h09;
  localparam opcode_t ALU_NOR   = 7'h0A;
  localparam opcode_t ALU_PASSA = 7'h0B;
  localparam opcode_t ALU_PASSB = 7'h0C;
  localparam opcode_t ALU_MUL   = 7'h0D;

  // Status flags travelling alongside the result.
  typedef struct packed {
    logic zero;
    logic negative;
    logic carry;
    logic overflow;
    logic illegal;
  } alu_flags_t;

  // Flag values seen after reset: result is 0, so zero is set.
  localparam alu_flags_t ALU_FLAGS_RST = '{zero: 1'b1, negative: 1'b0,
                                          carry: 1'b0, overflow: 1'b0,
                                          illegal: 1'b0};

endpackage

// File: rtl/alu_if.sv
// Operand/opcode in, registered result and flags out.
interface alu_if #(
  parameter int WIDTH = alu_pkg::ALU_WIDTH
);
  logic [WIDTH-1:0]           a;
  logic [WIDTH-1:0]           b;
  logic [alu_pkg::ALU_OPW-1:0] opcode;
  logic [WIDTH-1:0]           result;
  logic                       zero;
  logic                       negative;
  logic                       carry;
  logic                       overflow;
  logic                       illegal;

  modport master (
    output a, b, opcode,
    input  result, zero, negative, carry, overflow, illegal
  );

  modport slave (
    input  a, b, opcode,
    output result, zero, negative, carry, overflow, illegal
  );
endinterface

// File: rtl/alu_comb.sv
// Purely combinational ALU datapath: operands + opcode -> next result and flags.
module alu_comb
  import alu_pkg::*;
#(
  parameter int WIDTH = ALU_WIDTH
) (
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  input  opcode_t          opcode_i,
  output logic [WIDTH-1:0] result_o,
  output alu_flags_t       flags_o
);

  localparam int SHW = $clog2(WIDTH);

  logic [SHW-1:0]   shamt;
  logic [WIDTH:0]   sum_w;
  logic [WIDTH:0]   diff_w;
  logic [WIDTH-1:0] mul_w;
  logic             slt_w;
  logic             sltu_w;
  logic             add_ovf;
  logic             sub_ovf;
  logic [WIDTH-1:0] res;
  logic             carry;
  logic             ovf;
  logic             illegal;

  // Only the low bits of b select the shift distance.
  assign shamt  = b_i[SHW-1:0];

  // Subtraction as a + ~b + 1 so bit WIDTH is the not-borrow.
  assign sum_w  = {1'b0, a_i} + {1'b0, b_i};
  assign diff_w = {1'b0, a_i} + {1'b0, ~b_i} + {{WIDTH{1'b0}}, 1'b1};
  assign mul_w  = a_i * b_i;
  assign slt_w  = $signed(a_i) < $signed(b_i);
  assign sltu_w = a_i < b_i;

  // Signed overflow: operands agree in sign (ADD) or disagree (SUB) and the
  // result sign departs from a.
  assign add_ovf = (a_i[WIDTH-1] == b_i[WIDTH-1]) &&
                   (sum_w[WIDTH-1] != a_i[WIDTH-1]);
  assign sub_ovf = (a_i[WIDTH-1] != b_i[WIDTH-1]) &&
                   (diff_w[WIDTH-1] != a_i[WIDTH-1]);

  // Opcode decode; carry/overflow are only meaningful for ADD/SUB.
  always_comb begin
    res     = '0;
    carry   = 1'b0;
    ovf     = 1'b0;
    illegal = 1'b0;
    case (opcode_i)
      ALU_ADD: begin
        res   = sum_w[WIDTH-1:0];
        carry = sum_w[WIDTH];
        ovf   = add_ovf;
      end
      ALU_SUB: begin
        res   = diff_w[WIDTH-1:0];
        carry = diff_w[WIDTH];
        ovf   = sub_ovf;
      end
      ALU_AND:   res = a_i & b_i;
      ALU_OR:    res = a_i | b_i;
      ALU_XOR:   res = a_i ^ b_i;
      ALU_SLL:   res = a_i << shamt;
      ALU_SRL:   res = a_i >> shamt;
      ALU_SRA:   res = $signed(a_i) >>> shamt;
      ALU_SLT:   res = {{(WIDTH-1){1'b0}}, slt_w};
      ALU_SLTU:  res = {{(WIDTH-1){1'b0}}, sltu_w};
      ALU_NOR:   res = ~(a_i | b_i);
      ALU_PASSA: res = a_i;
      ALU_PASSB: res = b_i;
      ALU_MUL:   res = mul_w;
      default:   illegal = 1'b1;
    endcase
  end

  assign result_o          = res;
  assign flags_o.zero      = (res == '0);
  assign flags_o.negative  = res[WIDTH-1];
  assign flags_o.carry     = carry;
  assign flags_o.overflow  = ovf;
  assign flags_o.illegal   = illegal;

endmodule

// File: rtl/alu.sv
// ALU top: combinational datapath followed by a single output register stage.
module alu
  import alu_pkg::*;
#(
  parameter int WIDTH = ALU_WIDTH
) (
  input  logic  clk,
  input  logic  rst,
  alu_if.slave  bus
);

  logic [WIDTH-1:0] result_d, result_q;
  alu_flags_t       flags_d,  flags_q;

  alu_comb #(.WIDTH(WIDTH)) u_comb (
    .a_i      (bus.a),
    .b_i      (bus.b),
    .opcode_i (bus.opcode),
    .result_o (result_d),
    .flags_o  (flags_d)
  );

  // Output register; reset discards whatever was sampled on that edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      result_q <= '0;
      flags_q  <= ALU_FLAGS_RST;
    end else begin
      result_q <= result_d;
      flags_q  <= flags_d;
    end
  end

  assign bus.result   = result_q;
  assign bus.zero     = flags_q.zero;
  assign bus.negative = flags_q.negative;
  assign bus.carry    = flags_q.carry;
  assign bus.overflow = flags_q.overflow;
  assign bus.illegal  = flags_q.illegal;

endmodule

// File: tb/tb_alu.sv
// Self-checking bench for alu: directed corner vectors plus randomized ops
// against an arithmetic reference model.
module tb_alu;
  import alu_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   n_tests = 0;
  int   n_fail  = 0;

  always #5 clk = ~clk;

  alu_if bus ();

  alu dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // {result, zero, negative, carry, overflow, illegal}
  typedef logic [36:0] obs_t;

  function automatic obs_t observe();
    return {bus.result, bus.zero, bus.negative, bus.carry, bus.overflow, bus.illegal};
  endfunction

  // Reference model: wide integer arithmetic straight from the opcode table.
  function automatic obs_t model(logic [6:0] op, logic [31:0] a, logic [31:0] b);
    logic [63:0] ua, ub, w;
    longint      ss;
    int          sa, sb, sh;
    logic [31:0] r;
    logic        c, v, il;
    ua = {32'd0, a};
    ub = {32'd0, b};
    sa = $signed(a);
    sb = $signed(b);
    sh = int'(b[4:0]);
    r = 32'd0; c = 1'b0; v = 1'b0; il = 1'b0;
    case (op)
      7'h00: begin
        w  = ua + ub;
        r  = w[31:0];
        c  = w[32];
        ss = longint'(sa) + longint'(sb);
        v  = (ss != longint'($signed(ss[31:0])));
      end
      7'h01: begin
        w  = ua - ub;
        r  = w[31:0];
        c  = (ua >= ub);
        ss = longint'(sa) - longint'(sb);
        v  = (ss != longint'($signed(ss[31:0])));
      end
      7'h02: r = a & b;
      7'h03: r = a | b;
      7'h04: r = a ^ b;
      7'h05: begin w = ua << sh; r = w[31:0]; end
      7'h06: r = a >> sh;
      7'h07: r = sa >>> sh;
      7'h08: r = (sa < sb) ? 32'd1 : 32'd0;
      7'h09: r = (ua < ub) ? 32'd1 : 32'd0;
      7'h0A: r = ~(a | b);
      7'h0B: r = a;
      7'h0C: r = b;
      7'h0D: begin w = ua * ub; r = w[31:0]; end
      default: il = 1'b1;
    endcase
    return {r, (r == 32'd0), r[31], c, v, il};
  endfunction

  function automatic logic [31:0] rand_operand();
    case ($urandom_range(0, 7))
      0: return 32'h0000_0000;
      1: return 32'hFFFF_FFFF;
      2: return 32'h8000_0000;
      3: return 32'h7FFF_FFFF;
      4: return 32'($urandom_range(0, 40));
      default: return $urandom;
    endcase
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(logic [6:0] op, logic [31:0] a, logic [31:0] b);
    bus.opcode = op;
    bus.a      = a;
    bus.b      = b;
  endtask

  task automatic test_reset();
    obs_t got;
    drive(7'h00, 32'h1234_5678, 32'h1111_1111);
    rst = 1'b1;
    tick();
    tick();
    got = observe();
    n_tests++;
    if (got !== {32'd0, 5'b10000}) begin
      n_fail++;
      $display("FAIL reset_state got=%h want=%h", got, {32'd0, 5'b10000});
    end
    rst = 1'b0;
  endtask

  task automatic test_directed();
    logic [6:0]  op [12];
    logic [31:0] av [12];
    logic [31:0] bv [12];
    obs_t        ev [12];
    obs_t        got;
    op = '{7'h00, 7'h00, 7'h00, 7'h01, 7'h08, 7'h09,
           7'h07, 7'h06, 7'h05, 7'h7F, 7'h01, 7'h05};
    av = '{32'hFF00FF00, 32'h7FFFFFFF, 32'hFFFFFFFF, 32'h5, 32'h5, 32'hFFFFFFFF,
           32'h80000000, 32'h80000000, 32'h1, 32'hDEADBEEF, 32'h5, 32'hA5A5A5A5};
    bv = '{32'h00FF00FF, 32'h1, 32'h1, 32'h7, 32'h7, 32'h1,
           32'h24, 32'h24, 32'h1F, 32'h12345678, 32'h5, 32'h20};
    ev = '{{32'hFFFFFFFF, 5'b01000}, {32'h80000000, 5'b01010},
           {32'h00000000, 5'b10100}, {32'hFFFFFFFE, 5'b01000},
           {32'h00000001, 5'b00000}, {32'h00000000, 5'b10000},
           {32'hF8000000, 5'b01000}, {32'h08000000, 5'b00000},
           {32'h80000000, 5'b01000}, {32'h00000000, 5'b10001},
           {32'h00000000, 5'b10100}, {32'hA5A5A5A5, 5'b01000}};
    for (int i = 0; i < 12; i++) begin
      drive(op[i], av[i], bv[i]);
      tick();
      got = observe();
      n_tests++;
      if (got !== ev[i]) begin
        n_fail++;
        $display("FAIL directed[%0d] op=%h got=%h want=%h", i, op[i], got, ev[i]);
      end
    end
  endtask

  task automatic test_hold();
    obs_t exp_v, got;
    drive(7'h0D, 32'h0001_0003, 32'h0000_0007);
    exp_v = model(7'h0D, 32'h0001_0003, 32'h0000_0007);
    tick();
    drive(7'h04, 32'hFFFF_0000, 32'h0F0F_0F0F);
    #3;
    got = observe();
    n_tests++;
    if (got !== exp_v) begin
      n_fail++;
      $display("FAIL hold_between_edges got=%h want=%h", got, exp_v);
    end
    exp_v = model(7'h04, 32'hFFFF_0000, 32'h0F0F_0F0F);
    tick();
    got = observe();
    n_tests++;
    if (got !== exp_v) begin
      n_fail++;
      $display("FAIL hold_next_edge got=%h want=%h", got, exp_v);
    end
  endtask

  task automatic test_reset_midstream();
    obs_t exp_v, got;
    drive(7'h00, 32'h0000_0010, 32'h0000_0020);
    tick();
    rst = 1'b1;
    drive(7'h00, 32'h4000_0000, 32'h4000_0000);
    tick();
    got = observe();
    n_tests++;
    if (got !== {32'd0, 5'b10000}) begin
      n_fail++;
      $display("FAIL reset_midstream got=%h want=%h", got, {32'd0, 5'b10000});
    end
    rst = 1'b0;
    exp_v = model(7'h00, 32'h4000_0000, 32'h4000_0000);
    tick();
    got = observe();
    n_tests++;
    if (got !== exp_v) begin
      n_fail++;
      $display("FAIL after_reset_release got=%h want=%h", got, exp_v);
    end
  endtask

  task automatic test_back_to_back();
    logic [6:0]  op;
    logic [31:0] a, b;
    obs_t        exp_v, got;
    for (int i = 0; i < 600; i++) begin
      op = ($urandom_range(0, 9) == 0) ? 7'($urandom) : 7'($urandom_range(0, 13));
      a  = rand_operand();
      b  = rand_operand();
      drive(op, a, b);
      exp_v = model(op, a, b);
      tick();
      got = observe();
      n_tests++;
      if (got !== exp_v) begin
        n_fail++;
        $display("FAIL random[%0d] op=%h a=%h b=%h got=%h want=%h", i, op, a, b, got, exp_v);
      end
    end
  endtask

  initial begin
    drive(7'h00, 32'd0, 32'd0);
    test_reset();
    test_directed();
    test_hold();
    test_reset_midstream();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/alu.md
ALU -- requirements
Module: alu

Interface
REQ-001 Parameter: WIDTH, 32, operand/result width; all behaviour below is stated for WIDTH=32, and shift amount = low $clog2(WIDTH) bits of b.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst  input  1  reset, synchronous, active-high.
REQ-004 a  input  32  operand A.
REQ-005 b  input  32  operand B.
REQ-006 opcode  input  7  operation select.
REQ-007 result  output  32  registered operation result.
REQ-008 zero  output  1  registered; result==0.
REQ-009 negative  output  1  registered; result[31].
REQ-010 carry  output  1  registered; carry-out (ADD) or NOT borrow (SUB), else 0.
REQ-011 overflow  output  1  registered; signed overflow (ADD/SUB), else 0.
REQ-012 illegal  output  1  registered; opcode not in REQ-014 table.

Function
REQ-013 Outputs SHALL reflect a, b, opcode sampled at a rising edge, visible after that edge (latency 1 cycle); inputs are sampled every cycle, no handshake.
REQ-014 Opcode table (7'h): 00 ADD a+b; 01 SUB a-b; 02 AND; 03 OR; 04 XOR; 05 SLL a<<sh; 06 SRL logical; 07 SRA arithmetic; 08 SLT signed a<b ->1/0; 09 SLTU unsigned a<b ->1/0; 0A NOR; 0B PASSA a; 0C PASSB b; 0D MUL low 32 bits of a*b.
REQ-015 ADD/SUB SHALL wrap modulo 2^32; carry = bit 32 of a+b, or of a+~b+1 for SUB.
REQ-016 overflow SHALL be set for ADD when a,b same sign and result sign differs; for SUB when a,b differ in sign and result sign differs from a.
REQ-017 Shifts SHALL use b[4:0] only; shift by 0 returns a unchanged; SRA fills with a[31].
REQ-018 SLT/SLTU SHALL return 32'h1 or 32'h0; a==b returns 0.
REQ-019 Unlisted opcodes (0E..7F) SHALL yield result 0, zero=1, illegal=1, carry=overflow=0.
REQ-020 zero and negative SHALL be derived from the final result for every opcode, including logical ops.
REQ-021 Operand changes between edges SHALL NOT affect outputs until the next edge.

Reset
REQ-022 When rst is high at a rising edge, result=0, zero=1, negative=0, carry=0, overflow=0, illegal=0 after that edge, regardless of inputs.
REQ-023 rst asserted mid-stream SHALL discard the operation sampled that edge; first valid result appears one edge after rst deasserts.
REQ-024 Outputs before the first reset edge are undefined.

Structure
REQ-025 Opcode localparams (ALU_ADD..ALU_MUL) and WIDTH default SHALL live in a shared package alu_pkg.
REQ-026 Combinational compute SHALL be one sub-module alu_comb (a, b, opcode -> next result and flags); alu wraps it with the output register.

Verification
REQ-027 opcode=00, a=FF00FF00, b=00FF00FF -> next edge result=FFFFFFFF, zero=0, negative=1, carry=0, overflow=0.
REQ-028 opcode=00, a=7FFFFFFF, b=00000001 -> result=80000000, overflow=1, carry=0; a=FFFFFFFF,b=1 -> result=0, zero=1, carry=1.
REQ-029 opcode=01, a=5, b=7 -> result=FFFFFFFE, carry=0, negative=1; opcode=08 same operands -> 1; opcode=09 a=FFFFFFFF,b=1 -> 0.
REQ-030 opcode=07, a=80000000, b=00000024 (sh=4) -> F8000000; opcode=06 same -> 08000000; opcode=05 a=1, b=1F -> 80000000.
REQ-031 opcode=7F any operands -> result=0, illegal=1, zero=1.
REQ-032 Drive valid ADD, assert rst one cycle -> outputs take reset values after that edge; deassert -> next edge shows new result.
